// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory-stage load/store engine between a CPU pipeline and a word-wide,
//   combinational-read data memory. It aligns and extends byte/halfword loads
//   and performs byte/halfword stores as read-modify-write of the full word.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   req_valid          request strobe from the MEM stage (seen only when ready)
//   req_store          1 = store, 0 = load
//   req_size           00 byte, 01 halfword, 10 word, 11 reserved (error)
//   req_unsigned       load extension: 1 zero-extend, 0 sign-extend
//   req_addr           byte address
//   req_wdata          store data, right-justified
//   ready              idle, request accepted this cycle
//   done               one-cycle completion pulse
//   load_data          extended result of the most recent load
//   misalign_err       one-cycle pulse for a misaligned or reserved-size request
//   mem_addr           word-aligned memory address (0 while idle)
//   write_data         word to memory (0 unless writing)
//   memRead, memWrite  memory strobes, never both high
//   read_data          memory word, valid in the same cycle as memRead
module load_store_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misalign_err,
  output logic [31:0] mem_addr,
  output logic [31:0] write_data,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] read_data
);

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    WRITE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   merge_q, merge_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic                done_q, done_d;
  logic                misalign_q, misalign_d;

  // Size 11 is reserved and always rejected.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  // Pick the addressed little-endian lane and extend it to a full word.
  function automatic logic [DATA_W-1:0] extract_load(input logic [DATA_W-1:0] word,
                                                     input logic [1:0] size,
                                                     input logic [1:0] a,
                                                     input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    case (a)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   extract_load = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   extract_load = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: extract_load = word;
    endcase
  endfunction

  // Replace only the addressed byte/halfword lane of the old word.
  function automatic logic [DATA_W-1:0] merge_store(input logic [DATA_W-1:0] word,
                                                    input logic [1:0] size,
                                                    input logic [1:0] a,
                                                    input logic [DATA_W-1:0] wdata);
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] data;
    case (size)
      2'b00: begin
        mask = 32'h0000_00FF << {a, 3'b000};
        data = {24'd0, wdata[7:0]} << {a, 3'b000};
      end
      2'b01: begin
        mask = 32'h0000_FFFF << {a[1], 4'b0000};
        data = {16'd0, wdata[15:0]} << {a[1], 4'b0000};
      end
      default: begin
        mask = '0;
        data = '0;
      end
    endcase
    merge_store = (word & ~mask) | (data & mask);
  endfunction

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    unsigned_d  = unsigned_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    load_data_d = load_data_q;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    ready       = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    mem_addr    = '0;
    write_data  = '0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req_valid) begin
          if (is_misaligned(req_size, req_addr[1:0])) begin
            misalign_d = 1'b1;
          end else begin
            addr_d     = req_addr;
            size_d     = req_size;
            unsigned_d = req_unsigned;
            wdata_d    = req_wdata;
            if (!req_store)              state_d = LOAD;
            else if (req_size == 2'b10)  state_d = WRITE;
            else                         state_d = RMW_RD;
          end
        end
      end
      LOAD: begin
        memRead     = 1'b1;
        mem_addr    = {addr_q[31:2], 2'b00};
        load_data_d = extract_load(read_data, size_q, addr_q[1:0], unsigned_q);
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      RMW_RD: begin
        memRead  = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        merge_d  = read_data;
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        memWrite   = 1'b1;
        mem_addr   = {addr_q[31:2], 2'b00};
        write_data = merge_store(merge_q, size_q, addr_q[1:0], wdata_q);
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      WRITE: begin
        memWrite   = 1'b1;
        mem_addr   = {addr_q[31:2], 2'b00};
        write_data = wdata_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Strobes are killed immediately so a reset mid-operation cannot
    // leave a half-finished write in memory.
    if (reset) begin
      memRead  = 1'b0;
      memWrite = 1'b0;
    end
  end

  // Control and architecturally visible state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      load_data_q <= '0;
      merge_q     <= '0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
      load_data_q <= load_data_d;
      merge_q     <= merge_d;
    end
  end

  // Latched request fields; only meaningful once a request is accepted
  always_ff @(posedge clk) begin
    addr_q     <= addr_d;
    size_q     <= size_d;
    unsigned_q <= unsigned_d;
    wdata_q    <= wdata_d;
  end

  assign done         = done_q;
  assign misalign_err = misalign_q;
  assign load_data    = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ready;
  logic        done;
  logic [31:0] load_data;
  logic        misalign_err;
  logic [31:0] mem_addr;
  logic [31:0] write_data;
  logic        memRead;
  logic        memWrite;
  logic [31:0] read_data;

  int total;
  int bad;

  // Small data memory: combinational read, write on the clock edge.
  logic [31:0] mem [0:15];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [31:0] pl_val;

  assign read_data = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (memWrite)   mem[mem_addr[5:2]] <= write_data;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  load_store_unit dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_store    (req_store),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .ready        (ready),
    .done         (done),
    .load_data    (load_data),
    .misalign_err (misalign_err),
    .mem_addr     (mem_addr),
    .write_data   (write_data),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .read_data    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobes must never overlap in any cycle.
  always @(negedge clk) begin
    total++;
    assert (!(memRead && memWrite)) else begin
      bad++;
      $error("FAIL rw_excl observed memRead=%0b memWrite=%0b expected not both", memRead, memWrite);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] val);
    pl_idx = idx;
    pl_val = val;
    pl_en  = 1'b1;
    cyc();
    pl_en  = 1'b0;
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_store    = st;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = a;
    req_wdata    = wd;
    #1;
  endtask

  task automatic idle_req();
    req_valid = 1'b0;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    pl_en = 1'b0; pl_idx = '0; pl_val = '0;

    // Preload memory while the unit is held in reset.
    preload(4'd0, 32'h0000_0023);
    preload(4'd1, 32'h0000_0000);
    preload(4'd2, 32'h8101_0101);
    preload(4'd4, 32'h1122_3344);

    chk("rst_done", done, 1'b0);
    chk("rst_misalign", misalign_err, 1'b0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_memRead", memRead, 1'b0);
    chk("rst_memWrite", memWrite, 1'b0);

    reset = 1'b0;
    cyc();
    chk("post_rst_ready", ready, 1'b1);
    chk("idle_mem_addr", mem_addr, 32'h0);
    chk("idle_write_data", write_data, 32'h0);

    // lw 0x00
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0);
    chk("lw0_ready", ready, 1'b1);
    chk("lw0_idle_memRead", memRead, 1'b0);
    cyc(); idle_req();
    chk("lw0_memRead", memRead, 1'b1);
    chk("lw0_memWrite", memWrite, 1'b0);
    chk("lw0_mem_addr", mem_addr, 32'h0);
    chk("lw0_ready_busy", ready, 1'b0);
    chk("lw0_done_early", done, 1'b0);
    cyc();
    chk("lw0_done", done, 1'b1);
    chk("lw0_data", load_data, 32'h0000_0023);
    chk("lw0_memRead_off", memRead, 1'b0);
    cyc();
    chk("lw0_done_pulse", done, 1'b0);

    // lb 0x0B, then lbu 0x0B and lhu 0x0A back-to-back
    issue(1'b0, 2'b00, 1'b0, 32'h0000_000B, 32'h0);
    cyc(); idle_req();
    chk("lb_mem_addr", mem_addr, 32'h0000_0008);
    cyc();
    chk("lb_done", done, 1'b1);
    chk("lb_data", load_data, 32'hFFFF_FF81);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_000B, 32'h0);
    chk("lbu_b2b_ready", ready, 1'b1);
    cyc(); idle_req();
    chk("lbu_memRead", memRead, 1'b1);
    cyc();
    chk("lbu_data", load_data, 32'h0000_0081);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_000A, 32'h0);
    cyc(); idle_req();
    cyc();
    chk("lhu_done", done, 1'b1);
    chk("lhu_data", load_data, 32'h0000_8101);
    cyc();

    // sh 0x0A over word 0x01010101
    preload(4'd2, 32'h0101_0101);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_000A, 32'h1234_BEEF);
    cyc(); idle_req();
    chk("sh_rd_memRead", memRead, 1'b1);
    chk("sh_rd_memWrite", memWrite, 1'b0);
    chk("sh_rd_mem_addr", mem_addr, 32'h0000_0008);
    cyc();
    chk("sh_wr_memWrite", memWrite, 1'b1);
    chk("sh_wr_memRead", memRead, 1'b0);
    chk("sh_wr_data", write_data, 32'hBEEF_0101);
    chk("sh_wr_done_early", done, 1'b0);
    cyc();
    chk("sh_done", done, 1'b1);
    chk("sh_mem", mem[2], 32'hBEEF_0101);
    chk("sh_load_data_kept", load_data, 32'h0000_8101);
    cyc();

    // Misaligned lw 0x06 and reserved-size store
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0);
    chk("mis_lw_memRead_now", memRead, 1'b0);
    cyc(); idle_req();
    chk("mis_lw_err", misalign_err, 1'b1);
    chk("mis_lw_done", done, 1'b0);
    chk("mis_lw_memRead", memRead, 1'b0);
    chk("mis_lw_ready", ready, 1'b1);
    cyc();
    chk("mis_lw_err_pulse", misalign_err, 1'b0);
    issue(1'b1, 2'b11, 1'b0, 32'h0000_000C, 32'h55);
    cyc(); idle_req();
    chk("mis_sz_err", misalign_err, 1'b1);
    chk("mis_sz_memWrite", memWrite, 1'b0);
    chk("mis_sz_memRead", memRead, 1'b0);
    cyc();
    chk("mis_sz_done", done, 1'b0);
    chk("mis_sz_err_pulse", misalign_err, 1'b0);

    // sb 0x10 aborted by reset during RMW_RD
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h0000_00AA);
    cyc(); idle_req();
    chk("abort_rd_memRead", memRead, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_rst_memRead", memRead, 1'b0);
    chk("abort_rst_memWrite", memWrite, 1'b0);
    cyc();
    reset = 1'b0;
    #1;
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_memWrite", memWrite, 1'b0);
    chk("abort_load_data_rst", load_data, 32'h0);
    cyc();
    chk("abort_done2", done, 1'b0);
    chk("abort_mem", mem[4], 32'h1122_3344);

    // sw 0x04 then lw 0x04 issued in the done cycle
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'hDEAD_BEEF);
    cyc(); idle_req();
    chk("sw_memWrite", memWrite, 1'b1);
    chk("sw_memRead", memRead, 1'b0);
    chk("sw_data", write_data, 32'hDEAD_BEEF);
    chk("sw_mem_addr", mem_addr, 32'h0000_0004);
    cyc();
    chk("sw_done", done, 1'b1);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0);
    chk("sw_b2b_ready", ready, 1'b1);
    cyc(); idle_req();
    chk("lw4_memRead", memRead, 1'b1);
    chk("lw4_mem_addr", mem_addr, 32'h0000_0004);
    cyc();
    chk("lw4_done", done, 1'b1);
    chk("lw4_data", load_data, 32'hDEAD_BEEF);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
